pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register, successor to the fixed ID/EX latch.
- Carries an opaque payload of DATA_W bits between two stages, selected from a shared stall vector by STAGE.
- Adds a valid bit, a flush input, selectable bubble mode, and saturating stall/bubble performance counters.
- Instantiated between ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_stage_reg_pkg.sv | 30 +++
 rtl/pipe_stage_reg_sat_cnt.sv | 37 +++
 rtl/pipe_stage_reg.sv | 105 ++++++++++
 tb/tb_pipe_stage_reg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_pkg
// Description : Shared pipeline constants: stall levels, zero word, stage
//               indices into the global stall vector and per-stage NOP
//               payloads for the pipeline stage registers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

    // Stall vector levels
    localparam logic STOP     = 1'b1;
    localparam logic NOT_STOP = 1'b0;

    localparam logic [31:0] ZERO_32H = 32'h0000_0000;

    // Upstream stall-bit index of each stage register
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EX  = 3;
    localparam int STAGE_MEM = 4;

    // Default payload width and NOP payloads per instance
    localparam int PAYLOAD_W = 160;
    localparam logic [PAYLOAD_W-1:0] NOP_ID_EX  = '0;
    localparam logic [PAYLOAD_W-1:0] NOP_EX_MEM = '0;
    localparam logic [PAYLOAD_W-1:0] NOP_MEM_WB = '0;

endpackage : pipe_stage_reg_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : sat_cnt
// Description : Saturating up-counter with synchronous clear. Clear has
//               priority over increment; the count sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = &r_cnt;

    // Count up on i_inc until all-ones, zero on i_clr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule : sat_cnt
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised pipeline stage register with valid bit, flush,
//               selectable bubble mode and saturating stall/bubble counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W          = PAYLOAD_W,
    parameter int                STALL_W         = 6,
    parameter int                STAGE           = STAGE_ID,
    parameter logic [DATA_W-1:0] NOP_VALUE       = '0,
    parameter bit                CLEAR_ON_BUBBLE = 1'b1,
    parameter int                CNT_W           = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_dslot_next,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_dslot_next,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    // The downstream stall bit must exist inside the vector
    generate
        if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE out of range 0..STALL_W-2");
        end
    endgenerate

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_dslot;

    logic w_up_stall;
    logic w_dn_stall;
    logic w_bubble;
    logic w_stalled;

    assign w_up_stall = (stall[STAGE]   == STOP);
    assign w_dn_stall = (stall[STAGE+1] == STOP);
    // Upstream stopped while downstream keeps going: insert an empty slot.
    // The illegal pattern (upstream running, downstream stopped) falls
    // through to advance.
    assign w_bubble   = !flush && w_up_stall && !w_dn_stall;
    assign w_stalled  = !flush && w_up_stall;

    // Stage register: flush > bubble > advance > hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
            r_dslot <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
            r_dslot <= 1'b0;
        end else if (w_bubble) begin
            // Delay-slot marker is deliberately kept across a bubble
            r_valid <= 1'b0;
            if (CLEAR_ON_BUBBLE) begin
                r_data <= NOP_VALUE;
            end
        end else if (!w_up_stall) begin
            r_valid <= in_valid;
            r_data  <= in_data;
            r_dslot <= in_dslot_next;
        end
    end

    assign out_valid      = r_valid;
    assign out_data       = r_data;
    assign out_dslot_next = r_dslot;

    sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_stalled),
        .i_clr (cnt_clr),
        .o_cnt (stall_cnt)
    );

    sat_cnt #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_bubble),
        .i_clr (cnt_clr),
        .o_cnt (bubble_cnt)
    );

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg. Three
//               instances share stimulus: defaults, keep-on-bubble, and a
//               4-bit-counter variant with a non-zero NOP payload.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DW = 160;
    localparam int SW = 6;
    localparam logic [DW-1:0] NOP_S = 160'hDEAD;

    logic          clk;
    logic          reset;
    logic [SW-1:0] stall;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_dslot_next;
    logic          cnt_clr;

    logic          m_valid, k_valid, s_valid;
    logic [DW-1:0] m_data, k_data, s_data;
    logic          m_dslot, k_dslot, s_dslot;
    logic [15:0]   m_scnt, m_bcnt, k_scnt, k_bcnt;
    logic [3:0]    s_scnt, s_bcnt;

    int tests;
    int failed;

    logic [DW-1:0] d_a5, d1, d2, d3, d4, d5;

    pipe_stage_reg #(.STAGE(2)) u_main (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_dslot_next(in_dslot_next),
        .out_valid(m_valid), .out_data(m_data), .out_dslot_next(m_dslot),
        .cnt_clr(cnt_clr), .stall_cnt(m_scnt), .bubble_cnt(m_bcnt)
    );

    pipe_stage_reg #(.STAGE(2), .CLEAR_ON_BUBBLE(1'b0)) u_keep (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_dslot_next(in_dslot_next),
        .out_valid(k_valid), .out_data(k_data), .out_dslot_next(k_dslot),
        .cnt_clr(cnt_clr), .stall_cnt(k_scnt), .bubble_cnt(k_bcnt)
    );

    pipe_stage_reg #(.STAGE(2), .CNT_W(4), .NOP_VALUE(NOP_S)) u_small (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_dslot_next(in_dslot_next),
        .out_valid(s_valid), .out_data(s_data), .out_dslot_next(s_dslot),
        .cnt_clr(cnt_clr), .stall_cnt(s_scnt), .bubble_cnt(s_bcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_dslot !== 1'b0) begin
            failed++;
            $display("FAIL reset_main_out: valid=%b dslot=%b data=%h, want 0 0 0", m_valid, m_dslot, m_data);
        end
        tests++;
        if (s_data !== NOP_S || m_scnt !== 16'd0 || m_bcnt !== 16'd0) begin
            failed++;
            $display("FAIL reset_nop_cnt: s_data=%h scnt=%0d bcnt=%0d, want dead 0 0", s_data, m_scnt, m_bcnt);
        end
        in_valid = 1'b1; in_data = d_a5; in_dslot_next = 1'b1; stall = '0;
        reset = 1'b1;
        step();
        tests++;
        if (m_valid !== 1'b1 || m_data !== d_a5 || m_dslot !== 1'b1) begin
            failed++;
            $display("FAIL reset_first_edge: valid=%b dslot=%b data=%h, want 1 1 %h", m_valid, m_dslot, m_data, d_a5);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (m_valid !== 1'b0 || m_data !== '0 || s_data !== NOP_S) begin
            failed++;
            $display("FAIL reset_async: valid=%b data=%h s_data=%h, want 0 0 dead", m_valid, m_data, s_data);
        end
        reset = 1'b1;
    endtask

    task automatic test_bubble();
        in_valid = 1'b1; in_data = d1; in_dslot_next = 1'b1; stall = '0;
        step();
        in_data = d2; in_dslot_next = 1'b0; stall = 6'b000100;
        step();
        tests++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_dslot !== 1'b1) begin
            failed++;
            $display("FAIL bubble_clear: valid=%b dslot=%b data=%h, want 0 1 0", m_valid, m_dslot, m_data);
        end
        tests++;
        if (m_bcnt !== 16'd1 || m_scnt !== 16'd1) begin
            failed++;
            $display("FAIL bubble_cnt: bcnt=%0d scnt=%0d, want 1 1", m_bcnt, m_scnt);
        end
        tests++;
        if (k_valid !== 1'b0 || k_data !== d1 || k_dslot !== 1'b1) begin
            failed++;
            $display("FAIL bubble_keep: valid=%b dslot=%b data=%h, want 0 1 %h", k_valid, k_dslot, k_data, d1);
        end
        tests++;
        if (s_data !== NOP_S) begin
            failed++;
            $display("FAIL bubble_nop: data=%h, want dead", s_data);
        end
    endtask

    task automatic test_hold();
        // Advance d3 while clearing counters
        in_data = d3; in_dslot_next = 1'b0; stall = '0; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        tests++;
        if (m_valid !== 1'b1 || m_data !== d3 || m_scnt !== 16'd0 || m_bcnt !== 16'd0) begin
            failed++;
            $display("FAIL hold_setup: valid=%b data=%h scnt=%0d bcnt=%0d, want 1 %h 0 0", m_valid, m_data, m_scnt, m_bcnt, d3);
        end
        stall = 6'b001100;
        for (int i = 1; i <= 3; i++) begin
            in_data = d5 + DW'(i); in_valid = i[0]; in_dslot_next = 1'b1;
            step();
            tests++;
            if (m_valid !== 1'b1 || m_data !== d3 || m_dslot !== 1'b0 || m_scnt !== 16'(i) || m_bcnt !== 16'd0) begin
                failed++;
                $display("FAIL hold_cycle%0d: valid=%b dslot=%b data=%h scnt=%0d bcnt=%0d, want 1 0 %h %0d 0",
                         i, m_valid, m_dslot, m_data, m_scnt, m_bcnt, d3, i);
            end
        end
        stall = '0; in_data = d4; in_valid = 1'b1; in_dslot_next = 1'b1;
        step();
        tests++;
        if (m_valid !== 1'b1 || m_data !== d4 || m_dslot !== 1'b1) begin
            failed++;
            $display("FAIL hold_release: valid=%b dslot=%b data=%h, want 1 1 %h", m_valid, m_dslot, m_data, d4);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1; stall = 6'b000100;
        step();
        flush = 1'b0;
        tests++;
        if (m_valid !== 1'b0 || m_dslot !== 1'b0 || m_data !== '0 || k_data !== '0) begin
            failed++;
            $display("FAIL flush_out: valid=%b dslot=%b data=%h kdata=%h, want 0 0 0 0", m_valid, m_dslot, m_data, k_data);
        end
        tests++;
        if (m_scnt !== 16'd3 || m_bcnt !== 16'd0 || s_data !== NOP_S) begin
            failed++;
            $display("FAIL flush_cnt: scnt=%0d bcnt=%0d sdata=%h, want 3 0 dead", m_scnt, m_bcnt, s_data);
        end
    endtask

    task automatic test_saturate();
        stall = 6'b001100;
        repeat (20) step();
        tests++;
        if (s_scnt !== 4'd15 || m_scnt !== 16'd23) begin
            failed++;
            $display("FAIL sat_stick: small=%0d main=%0d, want 15 23", s_scnt, m_scnt);
        end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        tests++;
        if (s_scnt !== 4'd0 || m_scnt !== 16'd0 || s_bcnt !== 4'd0) begin
            failed++;
            $display("FAIL sat_clr: small=%0d main=%0d sbcnt=%0d, want 0 0 0", s_scnt, m_scnt, s_bcnt);
        end
        step();
        tests++;
        if (s_scnt !== 4'd1) begin
            failed++;
            $display("FAIL sat_after_clr: small=%0d, want 1", s_scnt);
        end
    endtask

    task automatic test_illegal();
        stall = 6'b001000; in_valid = 1'b0; in_data = d5; in_dslot_next = 1'b0;
        step();
        tests++;
        if (m_valid !== 1'b0 || m_data !== d5 || m_scnt !== 16'd1 || m_bcnt !== 16'd0) begin
            failed++;
            $display("FAIL illegal_advance: valid=%b data=%h scnt=%0d bcnt=%0d, want 0 %h 1 0", m_valid, m_data, m_scnt, m_bcnt, d5);
        end
    endtask

    initial begin
        tests = 0; failed = 0;
        d_a5 = {20{8'hA5}};
        d1 = {5{32'h1111_0001}};
        d2 = {5{32'h2222_0002}};
        d3 = {5{32'h3333_0003}};
        d4 = {5{32'h4444_0004}};
        d5 = {5{32'h5555_0005}};
        reset = 1'b0; stall = '0; flush = 1'b0; cnt_clr = 1'b0;
        in_valid = 1'b0; in_data = '0; in_dslot_next = 1'b0;
        step();
        test_reset();
        step();
        test_bubble();
        test_hold();
        test_flush();
        test_saturate();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
